// File: rtl/seg7_pkg.sv
// Shared types and helpers for the 7-segment scan multiplexer.
package seg7_pkg;
  localparam int NIBBLE_W   = 4;
  localparam int MAX_DIGITS = 8;

  typedef enum logic {BLANK, SHOW} slot_state_e;

  // One-hot digit enable for slot idx, sized for the widest display.
  function automatic logic [MAX_DIGITS-1:0] onehot(input logic [2:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction
endpackage

// File: rtl/seg7_scan_timer.sv
// Slot prescaler: cnt counts cycles within a slot, idx selects the digit.
// slot_idx / in_blank describe the cycle the scan enters on the next clock,
// so the parent can register its outputs and still line them up with cnt/idx.
// last_cycle_of_frame flags the current cycle as the frame's final cycle.
module seg7_scan_timer #(
  parameter  int NUM_DIGITS   = 4,
  parameter  int PRESCALE     = 50000,
  parameter  int BLANK_CYCLES = 16,
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [IW-1:0] slot_idx,
  output logic          in_blank,
  output logic          last_cycle_of_frame
);
  import seg7_pkg::*;

  localparam int CW = $clog2(PRESCALE);

  logic [CW-1:0] cnt, cnt_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic          slot_end;

  // Next-state of the slot counter and digit index.
  always_comb begin
    slot_end = (cnt == CW'(PRESCALE - 1));
    cnt_nxt  = slot_end ? '0 : cnt + CW'(1);
    idx_nxt  = idx;
    if (slot_end)
      idx_nxt = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
  end

  // Counter state; reset restarts the scan at slot 0, cycle 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= cnt_nxt;
      idx <= idx_nxt;
    end
  end

  assign slot_idx            = idx_nxt;
  assign in_blank            = (cnt_nxt < CW'(BLANK_CYCLES));
  assign last_cycle_of_frame = slot_end && (idx == IW'(NUM_DIGITS - 1));
endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed scan controller for a multi-digit 7-segment display.
// New frames are shadow-buffered and committed only on the last cycle of a
// frame, so a partially updated frame is never shown.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NIBBLE_W*NUM_DIGITS-1:0] value_i,
  input  logic                           load_i,
  output logic [NIBBLE_W-1:0]            digit_o,
  output logic [NUM_DIGITS-1:0]          digit_en_o,
  output logic                           frame_o,
  output logic                           pending_o
);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  if (BLANK_CYCLES < 1 || BLANK_CYCLES >= PRESCALE || PRESCALE < 2 ||
      NUM_DIGITS < 1 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_params
    $error("seg7_scan_mux: illegal NUM_DIGITS/PRESCALE/BLANK_CYCLES");
  end

  logic [NUM_DIGITS-1:0][NIBBLE_W-1:0] disp, shadow, frame_nxt;
  logic [IW-1:0]                       slot_idx;
  logic                                in_blank, commit;
  slot_state_e                         state_nxt;

  seg7_scan_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .PRESCALE    (PRESCALE),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .clk                (clk),
    .rst_n              (rst_n),
    .slot_idx           (slot_idx),
    .in_blank           (in_blank),
    .last_cycle_of_frame(commit)
  );

  // Frame visible next cycle: a load on the commit cycle bypasses the shadow.
  always_comb begin
    frame_nxt = disp;
    if (commit) begin
      if (load_i)         frame_nxt = value_i;
      else if (pending_o) frame_nxt = shadow;
    end
    state_nxt = in_blank ? BLANK : SHOW;
  end

  // Shadow/display buffers and registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow     <= '0;
      disp       <= '0;
      pending_o  <= 1'b0;
      digit_o    <= '0;
      digit_en_o <= '0;
      frame_o    <= 1'b0;
    end else begin
      if (load_i) shadow <= value_i;
      if (commit)      pending_o <= 1'b0;
      else if (load_i) pending_o <= 1'b1;
      disp       <= frame_nxt;
      // Nibble is presented during blanking too so the decoder settles early.
      digit_o    <= frame_nxt[slot_idx];
      digit_en_o <= (state_nxt == SHOW) ? NUM_DIGITS'(onehot(3'(slot_idx))) : '0;
      frame_o    <= commit;
    end
  end
endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux: hand-derived vector tables plus random loads
// compared against a time-indexed reference model.
module tb_seg7_scan_mux;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4-digit instance
  logic        rst_a_n = 1'b0, ld_a = 1'b0, fr_a, pd_a;
  logic [15:0] val_a = '0;
  logic [3:0]  dig_a, en_a;
  seg7_scan_mux #(.NUM_DIGITS(4), .PRESCALE(8), .BLANK_CYCLES(2)) dut_a (
    .clk(clk), .rst_n(rst_a_n), .value_i(val_a), .load_i(ld_a),
    .digit_o(dig_a), .digit_en_o(en_a), .frame_o(fr_a), .pending_o(pd_a));

  // 1-digit instance
  logic       rst_b_n = 1'b0, ld_b = 1'b0, fr_b, pd_b;
  logic [3:0] val_b = '0, dig_b;
  logic [0:0] en_b;
  seg7_scan_mux #(.NUM_DIGITS(1), .PRESCALE(4), .BLANK_CYCLES(1)) dut_b (
    .clk(clk), .rst_n(rst_b_n), .value_i(val_b), .load_i(ld_b),
    .digit_o(dig_b), .digit_en_o(en_b), .frame_o(fr_b), .pending_o(pd_b));

  typedef struct {
    int          t;   // cycle since reset release; -1 = apply reset
    logic        ld;
    logic [15:0] v;
    logic [7:0]  en;
    logic [3:0]  dig;
    logic        fr;
    logic        pd;
  } vec_t;

  vec_t tbl[$];
  int   nvec = 0, nerr = 0;
  int   t = 0;
  int   sel = 0;                 // 0: dut_a, 1: dut_b
  int   mn = 4, mp = 8, mb = 2;  // model geometry
  logic [3:0] shown[8];
  logic [3:0] mshadow[8];
  logic       mpend;

  function automatic logic [7:0] o_en();  return sel ? {7'b0, en_b} : {4'b0, en_a}; endfunction
  function automatic logic [3:0] o_dig(); return sel ? dig_b : dig_a; endfunction
  function automatic logic       o_fr();  return sel ? fr_b : fr_a; endfunction
  function automatic logic       o_pd();  return sel ? pd_b : pd_a; endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s dut=%0d t=%0d got %h want %h", nm, sel, t, act, exp);
    end
  endtask

  task automatic add(input int tt, input logic l, input logic [15:0] v,
                     input logic [7:0] en, input logic [3:0] d, input logic f, input logic p);
    vec_t x;
    x.t = tt; x.ld = l; x.v = v; x.en = en; x.dig = d; x.fr = f; x.pd = p;
    tbl.push_back(x);
  endtask

  task automatic model_clear();
    for (int k = 0; k < 8; k++) begin shown[k] = '0; mshadow[k] = '0; end
    mpend = 1'b0;
  endtask

  // Expected outputs from absolute time since reset.
  task automatic model_check();
    int slot, pos;
    logic [7:0] e;
    slot = (t / mp) % mn;
    pos  = t % mp;
    e = (pos < mb) ? 8'h00 : (8'h01 << slot);
    chk("en", 16'(o_en()), 16'(e));
    chk("digit", 16'(o_dig()), 16'(shown[slot]));
    chk("frame", 16'(o_fr()), 16'((t > 0) && (t % (mn * mp) == 0)));
    chk("pending", 16'(o_pd()), 16'(mpend));
  endtask

  task automatic model_step(input logic l, input logic [15:0] v);
    if (l) for (int k = 0; k < mn; k++) mshadow[k] = v[4*k +: 4];
    if (t % (mn * mp) == mn * mp - 1) begin
      if (l || mpend) for (int k = 0; k < mn; k++) shown[k] = mshadow[k];
      mpend = 1'b0;
    end else if (l) mpend = 1'b1;
  endtask

  task automatic drive(input logic l, input logic [15:0] v);
    if (sel == 1) begin ld_b = l; val_b = v[3:0]; end
    else          begin ld_a = l; val_a = v; end
  endtask

  task automatic set_rst(input logic r);
    if (sel == 1) rst_b_n = r; else rst_a_n = r;
  endtask

  // Check cycle t, apply this cycle's input, advance one clock.
  task automatic tick(input logic l, input logic [15:0] v);
    model_check();
    drive(l, v);
    model_step(l, v);
    @(negedge clk);
    t++;
    drive(1'b0, 16'h0);
  endtask

  task automatic reset_dut();
    drive(1'b0, 16'h0);
    set_rst(1'b0);
    @(negedge clk);
    chk("rst_en", 16'(o_en()), 16'h0);
    chk("rst_digit", 16'(o_dig()), 16'h0);
    chk("rst_frame", 16'(o_fr()), 16'h0);
    chk("rst_pending", 16'(o_pd()), 16'h0);
    repeat (2) @(negedge clk);
    set_rst(1'b1);
    t = 0;
    model_clear();
  endtask

  task automatic run_table();
    foreach (tbl[i]) begin
      if (tbl[i].t < 0) reset_dut();
      else begin
        while (t < tbl[i].t) tick(1'b0, 16'h0);
        chk("tbl_en", 16'(o_en()), 16'(tbl[i].en));
        chk("tbl_digit", 16'(o_dig()), 16'(tbl[i].dig));
        chk("tbl_frame", 16'(o_fr()), 16'(tbl[i].fr));
        chk("tbl_pending", 16'(o_pd()), 16'(tbl[i].pd));
        tick(tbl[i].ld, tbl[i].v);
      end
    end
    tbl.delete();
  endtask

  initial begin
    model_clear();
    @(negedge clk);

    // ---- 4 digits, PRESCALE 8, BLANK 2 ----
    sel = 0; mn = 4; mp = 8; mb = 2;
    // idle scan
    add(-1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 8'h0, 0, 0, 0);  add(1, 0, 0, 8'h0, 0, 0, 0);
    add(2, 0, 0, 8'h1, 0, 0, 0);  add(7, 0, 0, 8'h1, 0, 0, 0);
    add(8, 0, 0, 8'h0, 0, 0, 0);  add(10, 0, 0, 8'h2, 0, 0, 0);
    add(26, 0, 0, 8'h8, 0, 0, 0); add(31, 0, 0, 8'h8, 0, 0, 0);
    add(32, 0, 0, 8'h0, 0, 1, 0); add(33, 0, 0, 8'h0, 0, 0, 0);
    // single load, committed at frame boundary
    add(-1, 0, 0, 0, 0, 0, 0);
    add(3, 1, 16'h4321, 8'h1, 0, 0, 0); add(4, 0, 0, 8'h1, 0, 0, 1);
    add(31, 0, 0, 8'h8, 0, 0, 1);       add(32, 0, 0, 8'h0, 4'h1, 1, 0);
    add(34, 0, 0, 8'h1, 4'h1, 0, 0);    add(42, 0, 0, 8'h2, 4'h2, 0, 0);
    add(50, 0, 0, 8'h4, 4'h3, 0, 0);    add(58, 0, 0, 8'h8, 4'h4, 0, 0);
    // last load wins
    add(-1, 0, 0, 0, 0, 0, 0);
    add(5, 1, 16'hAAAA, 8'h1, 0, 0, 0); add(20, 1, 16'h5555, 8'h4, 0, 0, 1);
    add(32, 0, 0, 8'h0, 4'h5, 1, 0);    add(42, 0, 0, 8'h2, 4'h5, 0, 0);
    add(58, 0, 0, 8'h8, 4'h5, 0, 0);
    // load on the commit cycle bypasses the shadow
    add(-1, 0, 0, 0, 0, 0, 0);
    add(31, 1, 16'h00F0, 8'h8, 0, 0, 0); add(32, 0, 0, 8'h0, 4'h0, 1, 0);
    add(40, 0, 0, 8'h0, 4'hF, 0, 0);     add(48, 0, 0, 8'h0, 4'h0, 0, 0);
    add(56, 0, 0, 8'h0, 4'h0, 0, 0);
    run_table();

    // random loads, with extra weight on commit cycles
    reset_dut();
    for (int i = 0; i < 300; i++)
      tick(($urandom % 5 == 0) || ((t % 32 == 31) && ($urandom % 2 == 1)), 16'($urandom));

    // asynchronous reset mid-slot with a load pending
    reset_dut();
    while (t < 50) tick((t == 3) || (t == 45), (t == 3) ? 16'h4321 : 16'h9999);
    model_check();
    #2 rst_a_n = 1'b0;
    #1;
    chk("async_en", 16'(en_a), 16'h0);
    chk("async_digit", 16'(dig_a), 16'h0);
    chk("async_pending", 16'(pd_a), 16'h0);
    chk("async_frame", 16'(fr_a), 16'h0);
    repeat (2) @(negedge clk);
    rst_a_n = 1'b1;
    t = 0;
    model_clear();
    repeat (80) tick(1'b0, 16'h0);

    // ---- 1 digit, PRESCALE 4, BLANK 1 ----
    sel = 1; mn = 1; mp = 4; mb = 1;
    add(-1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 8'h0, 0, 0, 0);  add(1, 0, 0, 8'h1, 0, 0, 0);
    add(2, 1, 16'h7, 8'h1, 0, 0, 0); add(3, 0, 0, 8'h1, 0, 0, 1);
    add(4, 0, 0, 8'h0, 4'h7, 1, 0);  add(5, 0, 0, 8'h1, 4'h7, 0, 0);
    add(8, 0, 0, 8'h0, 4'h7, 1, 0);  add(12, 0, 0, 8'h0, 4'h7, 1, 0);
    run_table();
    for (int i = 0; i < 60; i++) tick($urandom % 3 == 0, 16'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/seg7_scan_mux.md
Name: seg7_scan_mux

Overview:
Time-multiplexed scan controller for a common-segment multi-digit 7-segment display.
- Sits directly upstream of the seg7 nibble-to-segment decoder.
- Holds a frame of NUM_DIGITS 4-bit nibbles, presents one nibble per time slot on digit_o (feeding the decoder), and drives the matching one-hot digit enable.
- New display values are shadow-buffered and committed only at frame boundaries, so the display never shows a partially updated frame (no tearing).
- Each slot begins with a blanking interval to suppress ghosting.

Parameters:
NUM_DIGITS, 4, number of display digits (1..8)
PRESCALE, 50000, clock cycles per digit slot (>= 2)
BLANK_CYCLES, 16, cycles at start of each slot with all enables off (1..PRESCALE-1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
value_i  input  4*NUM_DIGITS  new frame; digit k = value_i[4k+3:4k], digit 0 = rightmost
load_i  input  1  single-cycle strobe; captures value_i into shadow
digit_o  output  4  nibble for the current slot, to seg7 digit input
digit_en_o  output  NUM_DIGITS  one-hot active-high digit enable; all zero while blanking
frame_o  output  1  one-cycle pulse at the first cycle of slot 0 after every wrap
pending_o  output  1  shadow holds an uncommitted load

Behaviour:
- Clocking and reset:
  - One clock (clk).
  - Reset rst_n is asynchronous and active-low.
  - All state and outputs are registered.
- Reset values: cnt=0, idx=0, disp=0, shadow=0, pending_o=0, digit_o=0, digit_en_o=0, frame_o=0.
  - These values are asserted immediately on rst_n low, independent of clk.
- Counters:
  - cnt has width $clog2(PRESCALE) and counts 0..PRESCALE-1 within a slot.
  - idx has width max(1,$clog2(NUM_DIGITS)) and counts 0..NUM_DIGITS-1.
  - When cnt reaches PRESCALE-1, cnt returns to 0 and idx advances; idx wraps from NUM_DIGITS-1 to 0.
- Slot FSM, two states derived from cnt:
  - BLANK (cnt < BLANK_CYCLES): digit_en_o=0.
  - SHOW (cnt >= BLANK_CYCLES): digit_en_o = 1<<idx.
  - digit_o = disp[idx] in both states, so the decoder settles before its digit is enabled.
- Timing from reset: the first cycle after rst_n deasserts is cnt=0, idx=0, state BLANK. Frame period is NUM_DIGITS*PRESCALE cycles.
- Load:
  - load_i=1 writes value_i to shadow and sets pending_o=1.
  - Multiple loads within a frame: the last one wins.
- Commit cycle: the cycle with cnt=PRESCALE-1 and idx=NUM_DIGITS-1.
  - If pending_o=1, disp<=shadow and pending_o<=0.
  - If load_i=1 in this cycle, disp<=value_i directly (bypass) and pending_o<=0.
  - Either way the new frame is visible from the next cycle (cnt=0, idx=0).
- frame_o: high for exactly the cycle cnt=0, idx=0 that follows a commit cycle. Not asserted in the first slot after reset.
- NUM_DIGITS=1: idx is constant 0, every slot end is a commit cycle, and frame_o pulses every PRESCALE cycles.
- Reset mid-slot or mid-frame:
  - Shadow and pending loads are discarded.
  - Scan restarts at slot 0, BLANK.
- Parameter legality is checked with elaboration-time assertions: BLANK_CYCLES < PRESCALE, and 1 <= NUM_DIGITS <= 8.

Decomposition:
- Shared package seg7_pkg holds:
  - the localparam NIBBLE_W=4
  - a function onehot(idx) returning the enable vector
  - the slot-state enum {BLANK, SHOW}
- One natural sub-module: seg7_scan_timer.
  - Contains the cnt/idx prescaler.
  - Outputs slot_idx, in_blank, and last_cycle_of_frame.
  - The top level keeps shadow/disp/pending and the output muxing.
- The seg7 decoder is instantiated by the parent, not inside this block.

Test Plan:
All scenarios use NUM_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2 unless stated.
1. Reset released, no load -> digit_en_o=0000 in cycles 0-1, 0001 in cycles 2-7, 0000 in 8-9, 0010 in 10-15, ..., 1000 in 26-31; digit_o=0 throughout; frame_o=1 only at cycle 32.
2. load_i with value_i=16'h4321 at cycle 3 -> pending_o=1 from cycle 4; digit_o stays 0 through cycle 31; at cycle 32 frame_o=1 and pending_o=0; then digit_o=1,2,3,4 in slots 0-3 (cycles 32-39, 40-47, 48-55, 56-63).
3. load 16'hAAAA at cycle 5, then 16'h5555 at cycle 20 -> from cycle 32 every slot shows digit_o=5; A never appears.
4. load 16'h00F0 exactly at cycle 31 (commit cycle) -> from cycle 32 digit_o=0,F,0,0 for slots 0-3; pending_o never asserted.
5. rst_n low asynchronously at cycle 13 with a pending load -> digit_en_o=0, digit_o=0, pending_o=0 within the same cycle; after release the scan restarts at slot 0 and the old load never appears.
6. NUM_DIGITS=1, PRESCALE=4, BLANK_CYCLES=1 -> digit_en_o pattern 0,1,1,1 repeating; frame_o pulses at cycles 4, 8, 12; a load at cycle 2 is shown from cycle 4.
